imuldiv_muldiv_client: RTL

IMULDIV_MULDIV_CLIENT -- requirements
Module: imuldiv_muldiv_client

---
 rtl/imuldiv_muldiv_client.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/imuldiv_muldiv_client.sv
// Core-side client for an iterative mul/div unit: accepts one command, issues
// the unit request, captures the response and hands the result back to the core.
module imuldiv_muldiv_client (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cmd_val,
  output logic        o_cmd_rdy,
  input  logic [2:0]  i_cmd_fn,
  input  logic [31:0] i_cmd_a,
  input  logic [31:0] i_cmd_b,
  input  logic [4:0]  i_cmd_rd,
  output logic [2:0]  o_muldivreq_msg_fn,
  output logic [31:0] o_muldivreq_msg_a,
  output logic [31:0] o_muldivreq_msg_b,
  output logic        o_muldivreq_val,
  input  logic        i_muldivreq_rdy,
  input  logic [63:0] i_muldivresp_msg_result,
  input  logic        i_muldivresp_val,
  output logic        o_muldivresp_rdy,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_rd,
  output logic        o_wb_err,
  output logic        o_wb_val,
  input  logic        i_wb_rdy,
  output logic [7:0]  o_last_lat
);

  localparam int unsigned FN_W   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned LAT_W  = 8;

  localparam logic [FN_W-1:0]  FN_REM   = 3'd3;
  localparam logic [FN_W-1:0]  FN_REMU  = 3'd4;
  localparam logic [LAT_W-1:0] LAT_MAX  = 8'hFF;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_WB} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_cmd_rdy;
  logic                r_req_val;
  logic                r_resp_rdy;
  logic                r_wb_val;
  logic [FN_W-1:0]     r_fn;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [RD_W-1:0]     r_rd;
  logic [DATA_W-1:0]   r_wb_data;
  logic                r_wb_err;
  logic [LAT_W-1:0]    r_cnt;
  logic [LAT_W-1:0]    r_last_lat;
  logic                w_cmd_fire;
  logic                w_fn_valid;
  logic [DATA_W-1:0]   w_result;

  assign w_cmd_fire = i_cmd_val & r_cmd_rdy;
  assign w_fn_valid = (i_cmd_fn <= FN_REMU);

  // Next-state decode and result half selection ({rem,quot} for divides)
  always_comb begin
    w_state_nxt = r_state;
    w_result    = i_muldivresp_msg_result[DATA_W-1:0];
    if ((r_fn == FN_REM) || (r_fn == FN_REMU)) begin
      w_result = i_muldivresp_msg_result[2*DATA_W-1:DATA_W];
    end
    case (r_state)
      ST_IDLE: if (w_cmd_fire)       w_state_nxt = w_fn_valid ? ST_REQ : ST_WB;
      ST_REQ:  if (i_muldivreq_rdy)  w_state_nxt = ST_WAIT;
      ST_WAIT: if (i_muldivresp_val) w_state_nxt = ST_WB;
      ST_WB:   if (i_wb_rdy)         w_state_nxt = ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with handshake flags decoded one cycle ahead
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cmd_rdy  <= 1'b1;
      r_req_val  <= 1'b0;
      r_resp_rdy <= 1'b0;
      r_wb_val   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmd_rdy  <= (w_state_nxt == ST_IDLE);
      r_req_val  <= (w_state_nxt == ST_REQ);
      r_resp_rdy <= (w_state_nxt == ST_WAIT);
      r_wb_val   <= (w_state_nxt == ST_WB);
    end
  end

  // Command capture, wait-cycle counter and writeback payload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fn       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rd       <= '0;
      r_wb_data  <= '0;
      r_wb_err   <= 1'b0;
      r_cnt      <= '0;
      r_last_lat <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            r_fn <= i_cmd_fn;
            r_a  <= i_cmd_a;
            r_b  <= i_cmd_b;
            r_rd <= i_cmd_rd;
            if (w_fn_valid) begin
              r_wb_err <= 1'b0;
            end else begin
              r_wb_err   <= 1'b1;
              r_wb_data  <= '0;
              r_last_lat <= '0;
            end
          end
        end
        ST_REQ: begin
          if (i_muldivreq_rdy) r_cnt <= '0;
        end
        ST_WAIT: begin
          if (i_muldivresp_val) begin
            r_wb_data  <= w_result;
            r_last_lat <= r_cnt;
          end else if (r_cnt != LAT_MAX) begin
            r_cnt <= r_cnt + LAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_rdy          = r_cmd_rdy;
  assign o_muldivreq_val    = r_req_val;
  assign o_muldivreq_msg_fn = r_fn;
  assign o_muldivreq_msg_a  = r_a;
  assign o_muldivreq_msg_b  = r_b;
  assign o_muldivresp_rdy   = r_resp_rdy;
  assign o_wb_val           = r_wb_val;
  assign o_wb_data          = r_wb_data;
  assign o_wb_rd            = r_rd;
  assign o_wb_err           = r_wb_err;
  assign o_last_lat         = r_last_lat;

endmodule
